// File: rtl/dcache_pkg.sv
// Shared definitions for the dcache flush engine: FSM states, tag-entry field
// positions and the writeback line-address assembly helper.
package dcache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_CHECK,
        ST_WRITE,
        ST_UPDATE,
        ST_DONE
    } flushState_t;

    // Tag entry fields counted down from the top bit: valid, dirty, then the address tag.
    localparam int VALID_FROM_TOP    = 1;
    localparam int DIRTY_FROM_TOP    = 2;
    localparam int ADDR_TAG_FROM_TOP = 3;

    function automatic logic [63:0] lineAddr(input logic [63:0] tag,
                                             input logic [63:0] idx,
                                             input int          idxW,
                                             input int          offW);
        return ((tag << idxW) | idx) << offW;
    endfunction

endpackage

// File: rtl/dcache_flush_engine.sv
// Flush/writeback engine: walks every set of every way, writes dirty lines back
// to memory, then cleans or invalidates each line in the tag SRAM.
module dcache_flush_engine
    import dcache_pkg::*;
#(
    parameter int NUM_SETS = 16,
    parameter int NUM_WAYS = 2,
    parameter int LINE_W   = 256,
    parameter int TAG_W    = 25,
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 5,
    localparam int IDX_W   = $clog2(NUM_SETS),
    localparam int WAY_W   = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
    localparam int CNT_W   = $clog2(NUM_SETS * NUM_WAYS) + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_req_i,
    input  logic              mode_inv_i,
    input  logic              cache_idle_i,
    output logic              flush_busy_o,
    output logic              flush_done_o,
    output logic [IDX_W-1:0]  sram_idx_o,
    output logic [WAY_W-1:0]  sram_way_o,
    output logic              sram_rd_o,
    input  logic [TAG_W-1:0]  sram_tag_i,
    input  logic [LINE_W-1:0] sram_data_i,
    output logic              sram_clean_o,
    output logic              sram_inv_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic              mem_ack_i,
    output logic [CNT_W-1:0]  wb_count_o
);

    localparam int VALID_BIT   = TAG_W - VALID_FROM_TOP;
    localparam int DIRTY_BIT   = TAG_W - DIRTY_FROM_TOP;
    localparam int ADDR_TAG_HI = TAG_W - ADDR_TAG_FROM_TOP;

    flushState_t       state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WAY_W-1:0]  way_q, way_d;
    logic              invMode_q, invMode_d;
    logic [TAG_W-1:0]  lineTag_q, lineTag_d;
    logic [LINE_W-1:0] lineData_q, lineData_d;
    logic [CNT_W-1:0]  wbCount_q, wbCount_d;
    logic              advance;
    logic              lastLine;

    assign lastLine   = (idx_q == IDX_W'(NUM_SETS - 1)) && (way_q == WAY_W'(NUM_WAYS - 1));
    assign wb_count_o = wbCount_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            way_q      <= '0;
            invMode_q  <= 1'b0;
            lineTag_q  <= '0;
            lineData_q <= '0;
            wbCount_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            way_q      <= way_d;
            invMode_q  <= invMode_d;
            lineTag_q  <= lineTag_d;
            lineData_q <= lineData_d;
            wbCount_q  <= wbCount_d;
        end
    end

    // All port outputs decode from the state register, so reset clears them without waiting for a clock.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        way_d        = way_q;
        invMode_d    = invMode_q;
        lineTag_d    = lineTag_q;
        lineData_d   = lineData_q;
        wbCount_d    = wbCount_q;
        advance      = 1'b0;
        flush_busy_o = (state_q != ST_IDLE);
        flush_done_o = 1'b0;
        sram_idx_o   = idx_q;
        sram_way_o   = way_q;
        sram_rd_o    = 1'b0;
        sram_clean_o = 1'b0;
        sram_inv_o   = 1'b0;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;

        case (state_q)
            ST_IDLE: begin
                if (flush_req_i && cache_idle_i) begin
                    invMode_d = mode_inv_i;
                    wbCount_d = '0;
                    idx_d     = '0;
                    way_d     = '0;
                    state_d   = ST_READ;
                end
            end
            ST_READ: begin
                sram_rd_o  = 1'b1;
                lineTag_d  = sram_tag_i;
                lineData_d = sram_data_i;
                state_d    = ST_CHECK;
            end
            ST_CHECK: begin
                if (lineTag_q[VALID_BIT] && lineTag_q[DIRTY_BIT]) begin
                    state_d = ST_WRITE;
                end else begin
                    sram_inv_o = lineTag_q[VALID_BIT] && invMode_q;
                    advance    = 1'b1;
                end
            end
            ST_WRITE: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = ADDR_W'(lineAddr(64'(lineTag_q[ADDR_TAG_HI:0]), 64'(idx_q),
                                                IDX_W, OFFSET_W));
                mem_data_o   = lineData_q;
                if (mem_ack_i) begin
                    wbCount_d = wbCount_q + 1'b1;
                    state_d   = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                sram_inv_o   = invMode_q;
                sram_clean_o = !invMode_q;
                advance      = 1'b1;
            end
            ST_DONE: begin
                flush_done_o = 1'b1;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Pointer is {way, idx}: the set index wraps first, then the way steps.
        if (advance) begin
            if (lastLine) begin
                state_d = ST_DONE;
            end else begin
                state_d = ST_READ;
                idx_d   = idx_q + 1'b1;
                if (idx_q == IDX_W'(NUM_SETS - 1)) begin
                    idx_d = '0;
                    way_d = way_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dcache_flush_engine.sv
// Self-checking bench for dcache_flush_engine: a tag/data SRAM model, an acking
// memory model and scoreboard queues of expected writebacks and SRAM updates.
module tb_dcache_flush_engine;

    localparam int NUM_SETS = 16;
    localparam int NUM_WAYS = 2;
    localparam int LINE_W   = 256;
    localparam int TAG_W    = 25;
    localparam int ADDR_W   = 32;
    localparam int OFFSET_W = 5;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] data;
    } wrExp_t;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              flush_req_i = 1'b0;
    logic              mode_inv_i = 1'b0;
    logic              cache_idle_i = 1'b0;
    logic              flush_busy_o;
    logic              flush_done_o;
    logic [3:0]        sram_idx_o;
    logic [0:0]        sram_way_o;
    logic              sram_rd_o;
    logic [TAG_W-1:0]  sram_tag_i;
    logic [LINE_W-1:0] sram_data_i;
    logic              sram_clean_o;
    logic              sram_inv_o;
    logic              mem_enable_o;
    logic              mem_write_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [LINE_W-1:0] mem_data_o;
    logic              mem_ack_i = 1'b0;
    logic [5:0]        wb_count_o;

    logic [TAG_W-1:0]  tagMem  [NUM_WAYS][NUM_SETS];
    logic [LINE_W-1:0] dataMem [NUM_WAYS][NUM_SETS];

    wrExp_t     expWrQ[$];
    logic [7:0] expUpdQ[$];
    wrExp_t     cur;
    int         compared = 0;
    int         mismatched = 0;
    int         ackDelay = 0;
    int         ackWait = 0;
    int         holdCnt = 0;
    int         writesSeen = 0;
    int         expWb = 0;
    int         expWrites = 0;
    bit         inWrite = 0;

    dcache_flush_engine dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_req_i  (flush_req_i),
        .mode_inv_i   (mode_inv_i),
        .cache_idle_i (cache_idle_i),
        .flush_busy_o (flush_busy_o),
        .flush_done_o (flush_done_o),
        .sram_idx_o   (sram_idx_o),
        .sram_way_o   (sram_way_o),
        .sram_rd_o    (sram_rd_o),
        .sram_tag_i   (sram_tag_i),
        .sram_data_i  (sram_data_i),
        .sram_clean_o (sram_clean_o),
        .sram_inv_o   (sram_inv_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_ack_i    (mem_ack_i),
        .wb_count_o   (wb_count_o)
    );

    always #5 clk_i = ~clk_i;

    assign sram_tag_i  = tagMem[sram_way_o][sram_idx_o];
    assign sram_data_i = dataMem[sram_way_o][sram_idx_o];

    task automatic checkOutput(input string tag, input logic [LINE_W-1:0] actual,
                               input logic [LINE_W-1:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic clearCache();
        for (int w = 0; w < NUM_WAYS; w++) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                tagMem[w][s]  = '0;
                dataMem[w][s] = {8{32'hC0DE_0000 | 32'(w << 8) | 32'(s)}} ^ {8{$urandom}};
            end
        end
    endtask

    // Builds the expected writeback/update sequence from the current SRAM image in
    // walk order, then issues the request and returns just after the accepting edge.
    task automatic applyStimulus(input logic inv);
        logic [TAG_W-1:0] t;
        expWb = 0;
        writesSeen = 0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                t = tagMem[w][s];
                if (t[24] && t[23]) begin
                    expWrQ.push_back('{addr: (32'(t[22:0]) << 9) | (32'(s) << 5),
                                       data: dataMem[w][s]});
                    expUpdQ.push_back({1'b0, inv, !inv, 1'(w), 4'(s)});
                    expWb++;
                end else if (t[24] && inv) begin
                    expUpdQ.push_back({1'b0, 1'b1, 1'b0, 1'(w), 4'(s)});
                end
            end
        end
        expWrites = expWb;
        @(negedge clk_i);
        flush_req_i  = 1'b1;
        cache_idle_i = 1'b1;
        mode_inv_i   = inv;
        @(posedge clk_i);
        #1;
        flush_req_i = 1'b0;
    endtask

    task automatic waitDone(input int budget, output int cycles);
        bit seen;
        seen = 0;
        cycles = 0;
        while (!seen && cycles < budget) begin
            @(negedge clk_i);
            cycles++;
            if (flush_done_o) seen = 1;
        end
        checkOutput("doneSeen", LINE_W'(seen), LINE_W'(1));
    endtask

    task automatic checkFlushEnd(input string name);
        checkOutput({name, "_wbCount"}, LINE_W'(wb_count_o), LINE_W'(expWb));
        checkOutput({name, "_writes"}, LINE_W'(writesSeen), LINE_W'(expWrites));
        checkOutput({name, "_wrLeft"}, LINE_W'(expWrQ.size()), LINE_W'(0));
        checkOutput({name, "_updLeft"}, LINE_W'(expUpdQ.size()), LINE_W'(0));
    endtask

    // Monitor plus memory model: sampled on the falling edge, away from the DUT clock edge.
    initial begin
        logic [7:0] expUpd;
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                inWrite   = 0;
                ackWait   = 0;
                mem_ack_i = 1'b0;
            end else begin
                if (mem_enable_o) begin
                    if (!inWrite) begin
                        inWrite = 1;
                        holdCnt = 0;
                        writesSeen++;
                        checkOutput("writeExpected", LINE_W'(expWrQ.size() != 0), LINE_W'(1));
                        if (expWrQ.size() != 0) cur = expWrQ.pop_front();
                    end
                    holdCnt++;
                    checkOutput("memWrite", LINE_W'(mem_write_o), LINE_W'(1));
                    checkOutput("memAddr", LINE_W'(mem_addr_o), LINE_W'(cur.addr));
                    checkOutput("memData", mem_data_o, cur.data);
                end else if (inWrite) begin
                    inWrite = 0;
                    checkOutput("ackHold", LINE_W'(holdCnt), LINE_W'(ackDelay + 1));
                end
                if (sram_clean_o || sram_inv_o) begin
                    checkOutput("updExpected", LINE_W'(expUpdQ.size() != 0), LINE_W'(1));
                    expUpd = (expUpdQ.size() != 0) ? expUpdQ.pop_front() : 8'hFF;
                    checkOutput("sramUpdate",
                                LINE_W'({1'b0, sram_inv_o, sram_clean_o, sram_way_o, sram_idx_o}),
                                LINE_W'(expUpd));
                end
                if (mem_ack_i) begin
                    mem_ack_i = 1'b0;
                end else if (mem_enable_o) begin
                    if (ackWait >= ackDelay) begin
                        mem_ack_i = 1'b1;
                        ackWait   = 0;
                    end else begin
                        ackWait++;
                    end
                end
            end
        end
    end

    initial begin
        int  cycles;
        int  donePulses;
        bit  sawBusy;
        bit  sawWrite;

        clearCache();
        repeat (3) @(negedge clk_i);
        checkOutput("rstOutputs",
                    LINE_W'({flush_busy_o, flush_done_o, sram_rd_o, sram_clean_o, sram_inv_o,
                             mem_enable_o, mem_write_o, mem_addr_o, sram_idx_o, sram_way_o}),
                    LINE_W'(0));
        checkOutput("rstWbCount", LINE_W'(wb_count_o), LINE_W'(0));
        rst_i = 1'b1;

        $display("[TB] empty cache flush");
        applyStimulus(1'b0);
        checkOutput("firstRead", LINE_W'({sram_rd_o, sram_way_o, sram_idx_o}), LINE_W'(6'b1_0_0000));
        waitDone(2000, cycles);
        checkOutput("cleanLatency", LINE_W'(cycles), LINE_W'(1 + 2 * NUM_SETS * NUM_WAYS));
        checkFlushEnd("empty");

        $display("[TB] single dirty line, clean mode");
        clearCache();
        tagMem[0][3] = {1'b1, 1'b1, 23'h1};
        tagMem[1][0] = {1'b1, 1'b0, 23'h44};
        applyStimulus(1'b0);
        mode_inv_i = 1'b1;
        waitDone(2000, cycles);
        checkFlushEnd("dirty");

        $display("[TB] single dirty line, slow ack");
        ackDelay = 10;
        clearCache();
        tagMem[0][3] = {1'b1, 1'b1, 23'h1};
        applyStimulus(1'b0);
        waitDone(2000, cycles);
        checkFlushEnd("slowAck");
        ackDelay = 0;

        $display("[TB] invalidate mode");
        clearCache();
        tagMem[1][15] = {1'b1, 1'b0, 23'h5A5};
        tagMem[0][0]  = {1'b1, 1'b1, 23'h0};
        tagMem[0][7]  = {1'b0, 1'b1, 23'h7};
        tagMem[1][9]  = {1'b1, 1'b1, 23'h7F_FFFF};
        applyStimulus(1'b1);
        mode_inv_i = 1'b0;
        waitDone(2000, cycles);
        checkFlushEnd("inv");

        $display("[TB] reset during writeback");
        ackDelay = 50;
        clearCache();
        tagMem[0][5] = {1'b1, 1'b1, 23'h3};
        applyStimulus(1'b0);
        sawWrite = 0;
        for (int i = 0; i < 200 && !sawWrite; i++) begin
            @(negedge clk_i);
            if (mem_enable_o) sawWrite = 1;
        end
        checkOutput("writeStarted", LINE_W'(sawWrite), LINE_W'(1));
        repeat (2) @(negedge clk_i);
        #2;
        rst_i = 1'b0;
        #1;
        checkOutput("asyncRst",
                    LINE_W'({flush_busy_o, mem_enable_o, mem_write_o, mem_addr_o, sram_rd_o,
                             wb_count_o}),
                    LINE_W'(0));
        @(negedge clk_i);
        expWrQ.delete();
        expUpdQ.delete();
        ackDelay = 0;
        rst_i = 1'b1;
        clearCache();
        applyStimulus(1'b0);
        checkOutput("restartRead", LINE_W'({sram_rd_o, sram_way_o, sram_idx_o}), LINE_W'(6'b1_0_0000));
        waitDone(2000, cycles);
        checkFlushEnd("restart");

        $display("[TB] start gating and ignored second request");
        clearCache();
        sawBusy = 0;
        @(negedge clk_i);
        flush_req_i  = 1'b1;
        cache_idle_i = 1'b0;
        repeat (6) begin
            @(negedge clk_i);
            if (flush_busy_o) sawBusy = 1;
        end
        flush_req_i = 1'b0;
        checkOutput("idleGate", LINE_W'(sawBusy), LINE_W'(0));
        applyStimulus(1'b0);
        donePulses = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            if (i == 10) flush_req_i = 1'b1;
            if (i == 14) flush_req_i = 1'b0;
            if (flush_done_o) donePulses++;
        end
        checkOutput("donePulses", LINE_W'(donePulses), LINE_W'(1));
        checkOutput("busyAfter", LINE_W'(flush_busy_o), LINE_W'(0));
        checkFlushEnd("second");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL globalTimeout: got timeout, expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
